// File: rtl/alu_byte_sequencer_if.sv
// Byte-stream and result handshake bundle for alu_byte_sequencer.
//   din/din_op/din_valid/din_ready : operand byte stream (opcode rides with A byte 0)
//   res_f/res_zf/res_of            : captured ALU result and flags
//   res_valid/res_ready            : result handshake
// master = byte source / result consumer side, slave = sequencer side.
interface alu_byte_sequencer_if;
  logic [7:0]  din;
  logic [2:0]  din_op;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] res_f;
  logic        res_zf;
  logic        res_of;
  logic        res_valid;
  logic        res_ready;

  modport master (
    output din, din_op, din_valid, res_ready,
    input  din_ready, res_f, res_zf, res_of, res_valid
  );

  modport slave (
    input  din, din_op, din_valid, res_ready,
    output din_ready, res_f, res_zf, res_of, res_valid
  );
endinterface

// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer: front-end controller for the 32-bit combinational ALU.
// Collects operand A (4 bytes, little-endian, opcode with byte 0) and operand B
// (4 bytes) from an 8-bit stream, presents them on alu_a/alu_b/alu_op, captures
// alu_f/alu_zf/alu_of after one EXEC cycle and holds them under res_valid/res_ready.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : din, din_op, din_valid, din_ready, res_f, res_zf, res_of,
//                     res_valid, res_ready
//   alu_a/b/op      : registered operands/opcode to the ALU
//   alu_f/zf/of     : ALU result and flags
//   of_sticky       : accumulated overflow
// Optional feature macro: ALU_SEQ_STICKY_OF_EN (sticky overflow register);
// when undefined of_sticky is tied to 0.
module alu_byte_sequencer (
  input  logic                        clk,
  input  logic                        rst,
  alu_byte_sequencer_if.slave         bus,
  output logic [31:0]                 alu_a,
  output logic [31:0]                 alu_b,
  output logic [2:0]                  alu_op,
  input  logic [31:0]                 alu_f,
  input  logic                        alu_zf,
  input  logic                        alu_of,
  output logic                        of_sticky
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic [4:0] bit_base;

  // Byte k lands at bit 8k.
  assign bit_base = {cnt, 3'b000};

  // Only the load states accept bytes; anything offered elsewhere is dropped.
  assign bus.din_ready = (state == LOAD_A) || (state == LOAD_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD_A;
      cnt           <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      bus.res_f     <= '0;
      bus.res_zf    <= 1'b0;
      bus.res_of    <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (bus.din_valid) begin
            alu_a[bit_base +: 8] <= bus.din;
            if (cnt == 2'd0) alu_op <= bus.din_op;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (bus.din_valid) begin
            alu_b[bit_base +: 8] <= bus.din;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= EXEC;
          end
        end
        EXEC: begin
          bus.res_f     <= alu_f;
          bus.res_zf    <= alu_zf;
          bus.res_of    <= alu_of;
          bus.res_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_OF_EN
  logic of_sticky_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      of_sticky_q <= 1'b0;
    end else if (state == EXEC && alu_of) begin
      of_sticky_q <= 1'b1;
    end
  end

  assign of_sticky = of_sticky_q;
`else
  assign of_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Self-checking bench for alu_byte_sequencer: table of commands with hand-computed
// results, plus hand-written backpressure, mid-load reset and gapped-input cases.
// The bench models the external combinational ALU:
//   000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT (signed),
//   111 SLL (A << B[4:0]).
module tb_alu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] alu_a, alu_b, alu_f;
  logic [2:0]  alu_op;
  logic        alu_zf, alu_of, of_sticky;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_byte_sequencer_if bus ();

  alu_byte_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_f     (alu_f),
    .alu_zf    (alu_zf),
    .alu_of    (alu_of),
    .of_sticky (of_sticky)
  );

  always #5 clk = ~clk;

  // External ALU model.
  always_comb begin
    alu_f  = '0;
    alu_of = 1'b0;
    case (alu_op)
      3'b000: alu_f = alu_a & alu_b;
      3'b001: alu_f = alu_a | alu_b;
      3'b010: alu_f = alu_a ^ alu_b;
      3'b011: alu_f = ~(alu_a | alu_b);
      3'b100: begin
        alu_f  = alu_a + alu_b;
        alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
      end
      3'b101: begin
        alu_f  = alu_a - alu_b;
        alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
      end
      3'b110: alu_f = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_f = alu_a << alu_b[4:0];
    endcase
    alu_zf = (alu_f == 32'd0);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_f;
    logic        exp_zf;
    logic        exp_of;
  } vec_t;

  vec_t vecs [10];

`ifdef ALU_SEQ_STICKY_OF_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif
  logic exp_sticky = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [2:0] op, input int unsigned gap);
    bus.din_valid = 1'b0;
    bus.din       = 8'h5A;
    repeat (gap) tick();
    bus.din       = b;
    bus.din_op    = op;
    bus.din_valid = 1'b1;
    for (int unsigned w = 0; w < 50 && !bus.din_ready; w++) tick();
    if (!bus.din_ready) check("din_ready_timeout", {31'd0, bus.din_ready}, 32'd1);
    tick();
    bus.din_valid = 1'b0;
    bus.din_op    = 3'b000;
  endtask

  task automatic run_cmd(input vec_t v, input int unsigned gap, input int unsigned hold);
    logic [31:0] a, b;
    a = v.a;
    b = v.b;
    for (int unsigned k = 0; k < 4; k++) send_byte(a[8*k +: 8], v.op, gap);
    check("alu_a_loaded", alu_a, v.a);
    check("alu_op_loaded", {29'd0, alu_op}, {29'd0, v.op});
    for (int unsigned k = 0; k < 4; k++) send_byte(b[8*k +: 8], 3'b000, gap);
    check("alu_b_loaded", alu_b, v.b);
    check("res_valid_exec", {31'd0, bus.res_valid}, 32'd0);
    check("din_ready_exec", {31'd0, bus.din_ready}, 32'd0);
    tick();
    if (STICKY_EN) exp_sticky = exp_sticky | v.exp_of;
    check("res_valid_rise", {31'd0, bus.res_valid}, 32'd1);
    check("res_f", bus.res_f, v.exp_f);
    check("res_zf", {31'd0, bus.res_zf}, {31'd0, v.exp_zf});
    check("res_of", {31'd0, bus.res_of}, {31'd0, v.exp_of});
    check("of_sticky", {31'd0, of_sticky}, {31'd0, exp_sticky});
    // Backpressure: bytes offered while holding must be ignored.
    bus.din       = 8'hAA;
    bus.din_valid = (hold != 0);
    for (int unsigned h = 0; h < hold; h++) begin
      tick();
      check("hold_din_ready", {31'd0, bus.din_ready}, 32'd0);
      check("hold_res_valid", {31'd0, bus.res_valid}, 32'd1);
      check("hold_res_f", bus.res_f, v.exp_f);
    end
    bus.din_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("res_valid_clear", {31'd0, bus.res_valid}, 32'd0);
    check("din_ready_after", {31'd0, bus.din_ready}, 32'd1);
    check("res_f_kept", bus.res_f, v.exp_f);
  endtask

  task automatic check_reset_values();
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", {29'd0, alu_op}, 32'd0);
    check("rst_res_f", bus.res_f, 32'd0);
    check("rst_res_zf", {31'd0, bus.res_zf}, 32'd0);
    check("rst_res_of", {31'd0, bus.res_of}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_of_sticky", {31'd0, of_sticky}, 32'd0);
    check("rst_din_ready", {31'd0, bus.din_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{3'b100, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
    vecs[1] = '{3'b101, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{3'b110, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 1'b0, 1'b0};
    vecs[3] = '{3'b001, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0, 1'b0};
    vecs[4] = '{3'b111, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0, 1'b0};
    vecs[5] = '{3'b000, 32'hF0F0_F0F0, 32'h0FF0_FF00, 32'h00F0_F000, 1'b0, 1'b0};
    vecs[6] = '{3'b010, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1'b0, 1'b0};
    vecs[7] = '{3'b011, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8] = '{3'b101, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[9] = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};

    bus.din       = 8'h00;
    bus.din_op    = 3'b000;
    bus.din_valid = 1'b0;
    bus.res_ready = 1'b0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_values();

    for (int unsigned i = 0; i < 10; i++) begin
      if (i == 3) begin
        // Abort a partially loaded command: 5 bytes in, then reset with a byte offered.
        for (int unsigned k = 0; k < 5; k++) send_byte(8'h11 + 8'(k), 3'b010, 0);
        bus.din       = 8'h55;
        bus.din_valid = 1'b1;
        rst           = 1'b1;
        tick();
        rst           = 1'b0;
        bus.din_valid = 1'b0;
        exp_sticky    = 1'b0;
        check_reset_values();
      end
      run_cmd(vecs[i], (i == 4) ? 3 : 0, (i == 2) ? 4 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
